sc_chain_ctrl: RTL

//  Sequencer for a serial chain of two-phase scan cells. Single-clock, synchronous FSM.

---
 rtl/sc_chain_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sc_chain_ctrl.sv
// sc_chain_ctrl: sequencer for a serial chain of two-phase scan cells.
// Drives non-overlapping SCK1/SCK2 pulses plus SEL and LAT. A run is an
// optional parallel capture, then CHAIN_LEN shift slots, then an optional
// LAT update. Each slot is GAP_CYC cycles with all strobes low, followed by
// PH_CYC cycles with exactly one strobe high.
// Optional feature macro: SC_CTRL_DOUT_EN. When it is defined, SC_SO is
// sampled into DOUT during shifting. When it is not defined, DOUT is tied
// to 0 and the sequencing and timing are unchanged.
//
// Handshake: START is a level request that is sampled only in IDLE. On that
// edge CAPTURE, UPDATE and DIN are latched. BUSY is high for every slot
// cycle of the run. DONE is a single-cycle pulse after BUSY falls. START is
// ignored while BUSY is high and during the DONE cycle.
module sc_chain_ctrl #(
   parameter int CHAIN_LEN = 16,
   parameter int PH_CYC    = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 START,
   input  logic                 CAPTURE,
   input  logic                 UPDATE,
   input  logic [CHAIN_LEN-1:0] DIN,
   output logic [CHAIN_LEN-1:0] DOUT,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 SC_SIN,
   input  logic                 SC_SO,
   output logic                 SC_SEL,
   output logic                 SC_LAT,
   output logic                 SC_SCK1,
   output logic                 SC_SCK2
);

   localparam int MAX_PH = (PH_CYC > GAP_CYC) ? PH_CYC : GAP_CYC;
   localparam int PW     = $clog2(MAX_PH + 1);
   localparam int BW     = $clog2(CHAIN_LEN + 1);
   localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYC - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(PH_CYC - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CAP1  = 3'd1,
      S_CAP2  = 3'd2,
      S_SH1   = 3'd3,
      S_SH2   = 3'd4,
      S_LATCH = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic                  pulse_q, pulse_d;      // 0: gap part of slot, 1: pulse part
   logic [PW-1:0]         ph_cnt_q, ph_cnt_d;    // cycle within current gap/pulse part
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;  // index k of the bit being shifted
   logic                  upd_q, upd_d;
   logic [CHAIN_LEN-1:0]  din_q, din_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  sin_q, sin_d;
   logic                  sel_q, sel_d;
   logic                  lat_q, lat_d;
   logic                  sck1_q, sck1_d;
   logic                  sck2_q, sck2_d;

   // Next-state and next-output logic; all outputs are registered from the next state
   always_comb begin
      state_d   = state_q;
      pulse_d   = pulse_q;
      ph_cnt_d  = ph_cnt_q;
      bit_cnt_d = bit_cnt_q;
      upd_d     = upd_q;
      din_d     = din_q;
      sin_d     = sin_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               upd_d     = UPDATE;
               din_d     = DIN;
               state_d   = CAPTURE ? S_CAP1 : S_SH1;
               pulse_d   = 1'b0;
               ph_cnt_d  = '0;
               bit_cnt_d = '0;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            if (!pulse_q) begin
               if (ph_cnt_q == GAP_LAST) begin
                  pulse_d  = 1'b1;
                  ph_cnt_d = '0;
               end else begin
                  ph_cnt_d = ph_cnt_q + PW'(1);
               end
            end else if (ph_cnt_q != PH_LAST) begin
               ph_cnt_d = ph_cnt_q + PW'(1);
            end else begin
               // end of slot: advance to the next slot's first gap cycle
               pulse_d  = 1'b0;
               ph_cnt_d = '0;
               case (state_q)
                  S_CAP1: state_d = S_CAP2;
                  S_CAP2: state_d = S_SH1;
                  S_SH1:  state_d = S_SH2;
                  S_SH2: begin
                     if (bit_cnt_q == BIT_LAST) begin
                        state_d = upd_q ? S_LATCH : S_DONE;
                     end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = S_SH1;
                     end
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      sel_d  = (state_d == S_CAP1) || (state_d == S_CAP2);
      sck1_d = pulse_d && ((state_d == S_CAP1) || (state_d == S_SH1));
      sck2_d = pulse_d && ((state_d == S_CAP2) || (state_d == S_SH2));
      lat_d  = pulse_d && (state_d == S_LATCH);

      // SIN only moves on entry to an SH1 slot, i.e. in its first gap cycle
      if ((state_d == S_SH1) && (state_q != S_SH1)) begin
         for (int i = 0; i < CHAIN_LEN; i++) begin
            if (bit_cnt_d == BW'(CHAIN_LEN - 1 - i)) sin_d = din_d[i];
         end
      end
   end

   // State, counters and registered outputs; reset aborts any run immediately
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         pulse_q   <= 1'b0;
         ph_cnt_q  <= '0;
         bit_cnt_q <= '0;
         upd_q     <= 1'b0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sin_q     <= 1'b0;
         sel_q     <= 1'b0;
         lat_q     <= 1'b0;
         sck1_q    <= 1'b0;
         sck2_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         ph_cnt_q  <= ph_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         upd_q     <= upd_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sin_q     <= sin_d;
         sel_q     <= sel_d;
         lat_q     <= lat_d;
         sck1_q    <= sck1_d;
         sck2_q    <= sck2_d;
      end
   end

`ifdef SC_CTRL_DOUT_EN
   logic [CHAIN_LEN-1:0] dout_q, dout_d;

   // Sample SC_SO in the last gap cycle of each SH1 slot: sample k lands in DOUT[CHAIN_LEN-1-k]
   always_comb begin
      dout_d = dout_q;
      if ((state_q == S_SH1) && !pulse_q && (ph_cnt_q == GAP_LAST)) begin
         for (int i = 0; i < CHAIN_LEN; i++) begin
            if (bit_cnt_q == BW'(CHAIN_LEN - 1 - i)) dout_d[i] = SC_SO;
         end
      end
   end

   // DOUT register, updated in place and held between runs
   always_ff @(posedge CLK) begin
      if (!RST_N) dout_q <= '0;
      else        dout_q <= dout_d;
   end

   assign DOUT = dout_q;
`else
   logic unused_so;
   assign unused_so = SC_SO;
   assign DOUT      = '0;
`endif

   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign SC_SIN  = sin_q;
   assign SC_SEL  = sel_q;
   assign SC_LAT  = lat_q;
   assign SC_SCK1 = sck1_q;
   assign SC_SCK2 = sck2_q;

endmodule
